// File: rtl/qch_pkg.sv
// Shared types and constants for the Q-channel power controller.
package qch_pkg;

  typedef enum logic [1:0] {
    Q_RUN     = 2'd0,
    Q_REQUEST = 2'd1,
    Q_STOPPED = 2'd2,
    Q_EXIT    = 2'd3
  } qch_state_t;

  localparam int unsigned QCH_SYNC_STAGES = 2;

endpackage

// File: rtl/qch_sync2.sv
// Multi-flop synchroniser for a single asynchronous level signal.
// The reset value is chosen per instance so the synced level starts inactive.
module qch_sync2
  import qch_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [QCH_SYNC_STAGES-1:0] r_sync;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {QCH_SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[QCH_SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[QCH_SYNC_STAGES-1];

endmodule

// File: rtl/qch_power_controller.sv
// Q-channel power controller: requests quiescence after an idle period, gates the
// device clock while stopped and wakes the device on activity or software request.
// Optional statistics counters are built only when QCH_STATS_EN is defined;
// otherwise stop_cnt_o and stop_cycles_o are tied to zero.
module qch_power_controller
  import qch_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_i,
  input  logic              wake_req_i,
  input  logic              qactive_i,
  input  logic              qacceptn_i,
  output logic              qreqn_o,
  output logic              clk_en_o,
  output logic [1:0]        pwr_state_o,
  output logic              proto_err_o,
  output logic [STAT_W-1:0] stop_cnt_o,
  output logic [STAT_W-1:0] stop_cycles_o
);

  localparam int unsigned CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES - 1);

  logic w_qactive_s;
  logic w_qacceptn_s;
  logic w_idle;
  logic w_err_set;

  qch_state_t       r_state;
  qch_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] w_idle_cnt_nxt;
  logic             r_qreqn;
  logic             r_clk_en;
  logic             r_proto_err;

  qch_sync2 #(
    .RESET_VAL (1'b0)
  ) u_sync_qactive (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (qactive_i),
    .q_o     (w_qactive_s)
  );

  qch_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync_qacceptn (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (qacceptn_i),
    .q_o     (w_qacceptn_s)
  );

  assign w_idle = ~w_qactive_s & enable_i & ~wake_req_i;

  // Next-state and idle-counter logic; the counter only runs in RUN and is zero elsewhere.
  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = '0;
    unique case (r_state)
      Q_RUN: begin
        if (w_idle) begin
          if (r_idle_cnt == CNT_MAX) begin
            w_state_nxt    = Q_REQUEST;
            w_idle_cnt_nxt = r_idle_cnt;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + CNT_W'(1);
          end
        end
      end
      // No deny path: once requested, wait for accept regardless of activity or wake.
      Q_REQUEST: begin
        if (!w_qacceptn_s) begin
          w_state_nxt = Q_STOPPED;
        end
      end
      Q_STOPPED: begin
        if (w_qactive_s || wake_req_i || !enable_i) begin
          w_state_nxt = Q_EXIT;
        end
      end
      Q_EXIT: begin
        if (w_qacceptn_s) begin
          w_state_nxt = Q_RUN;
        end
      end
      default: begin
        w_state_nxt = Q_RUN;
      end
    endcase
  end

  // State, counter and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= Q_RUN;
      r_idle_cnt <= '0;
      r_qreqn    <= 1'b1;
      r_clk_en   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= (w_state_nxt == Q_RUN) ? w_idle_cnt_nxt : '0;
      r_qreqn    <= !((w_state_nxt == Q_REQUEST) || (w_state_nxt == Q_STOPPED));
      r_clk_en   <= (w_state_nxt != Q_STOPPED);
    end
  end

  // Accept low in RUN or accept high in STOPPED is a device protocol violation.
  assign w_err_set = ((r_state == Q_RUN) && !w_qacceptn_s) ||
                     ((r_state == Q_STOPPED) && w_qacceptn_s);

  // Sticky protocol error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_proto_err <= 1'b0;
    end else if (w_err_set) begin
      r_proto_err <= 1'b1;
    end
  end

  assign qreqn_o     = r_qreqn;
  assign clk_en_o    = r_clk_en;
  assign pwr_state_o = r_state;
  assign proto_err_o = r_proto_err;

`ifdef QCH_STATS_EN
  logic [STAT_W-1:0] r_stop_cnt;
  logic [STAT_W-1:0] r_stop_cycles;
  logic              w_stop_entry;

  assign w_stop_entry = (r_state == Q_REQUEST) && (w_state_nxt == Q_STOPPED);

  // Saturating counts of STOPPED entries and of cycles spent in STOPPED.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stop_cnt    <= '0;
      r_stop_cycles <= '0;
    end else begin
      if (w_stop_entry && (r_stop_cnt != '1)) begin
        r_stop_cnt <= r_stop_cnt + STAT_W'(1);
      end
      if ((r_state == Q_STOPPED) && (r_stop_cycles != '1)) begin
        r_stop_cycles <= r_stop_cycles + STAT_W'(1);
      end
    end
  end

  assign stop_cnt_o    = r_stop_cnt;
  assign stop_cycles_o = r_stop_cycles;
`else
  assign stop_cnt_o    = '0;
  assign stop_cycles_o = '0;
`endif

endmodule

// File: tb/tb_qch_power_controller.sv
// Directed self-checking bench for qch_power_controller with IDLE_CYCLES=4.
module tb_qch_power_controller;

  localparam int unsigned IDLE_CYCLES = 4;
  localparam int unsigned STAT_W      = 16;

  logic              clk;
  logic              reset_n;
  logic              enable_i;
  logic              wake_req_i;
  logic              qactive_i;
  logic              qacceptn_i;
  logic              qreqn_o;
  logic              clk_en_o;
  logic [1:0]        pwr_state_o;
  logic              proto_err_o;
  logic [STAT_W-1:0] stop_cnt_o;
  logic [STAT_W-1:0] stop_cycles_o;

  int n_cmp;
  int n_err;

  qch_power_controller #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .STAT_W      (STAT_W)
  ) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable_i      (enable_i),
    .wake_req_i    (wake_req_i),
    .qactive_i     (qactive_i),
    .qacceptn_i    (qacceptn_i),
    .qreqn_o       (qreqn_o),
    .clk_en_o      (clk_en_o),
    .pwr_state_o   (pwr_state_o),
    .proto_err_o   (proto_err_o),
    .stop_cnt_o    (stop_cnt_o),
    .stop_cycles_o (stop_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    enable_i   = 1'b0;
    wake_req_i = 1'b0;
    qactive_i  = 1'b1;
    qacceptn_i = 1'b0;

    // Reset with hostile device inputs
    tick(2);
    check_eq("rst_qreqn", qreqn_o, 1);
    check_eq("rst_clk_en", clk_en_o, 1);
    check_eq("rst_state", pwr_state_o, 0);
    check_eq("rst_err", proto_err_o, 0);
    check_eq("rst_stop_cnt", stop_cnt_o, 0);
    check_eq("rst_stop_cycles", stop_cycles_o, 0);
    qacceptn_i = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(3);
    check_eq("post_rst_state", pwr_state_o, 0);
    check_eq("post_rst_err", proto_err_o, 0);

    // Idle entry: request exactly IDLE_CYCLES+2 cycles after qactive_i falls
    enable_i  = 1'b1;
    qactive_i = 1'b0;
    tick(5);
    check_eq("idle_qreqn_early", qreqn_o, 1);
    check_eq("idle_state_early", pwr_state_o, 0);
    tick(1);
    check_eq("idle_qreqn", qreqn_o, 0);
    check_eq("idle_state_req", pwr_state_o, 1);
    check_eq("idle_clk_en", clk_en_o, 1);
    qacceptn_i = 1'b0;
    tick(2);
    check_eq("acc_state_early", pwr_state_o, 1);
    check_eq("acc_clk_en_early", clk_en_o, 1);
    tick(1);
    check_eq("acc_state_stop", pwr_state_o, 2);
    check_eq("acc_clk_en", clk_en_o, 0);
    check_eq("acc_qreqn", qreqn_o, 0);

    // Wake on device activity
    qactive_i = 1'b1;
    tick(2);
    check_eq("wake_state_early", pwr_state_o, 2);
    tick(1);
    check_eq("wake_state_exit", pwr_state_o, 3);
    check_eq("wake_qreqn", qreqn_o, 1);
    check_eq("wake_clk_en", clk_en_o, 1);
    qacceptn_i = 1'b1;
    tick(2);
    check_eq("exit_state_early", pwr_state_o, 3);
    tick(1);
    check_eq("exit_state_run", pwr_state_o, 0);
    check_eq("exit_err", proto_err_o, 0);

    // Busy glitch restarts the idle count from zero
    qactive_i = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i == 3) qactive_i = 1'b1;
      if (i == 4) qactive_i = 1'b0;
      check_eq("glitch_qreqn", qreqn_o, (i == 10) ? 32'd0 : 32'd1);
    end
    check_eq("glitch_state", pwr_state_o, 1);

    // Wake during REQUEST cannot cancel; one STOPPED cycle then EXIT
    wake_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_eq("hold_qreqn", qreqn_o, 0);
      check_eq("hold_state", pwr_state_o, 1);
    end
    qacceptn_i = 1'b0;
    tick(2);
    check_eq("hold_acc_state_early", pwr_state_o, 1);
    tick(1);
    check_eq("hold_stop_state", pwr_state_o, 2);
    check_eq("hold_stop_clk_en", clk_en_o, 0);
    tick(1);
    check_eq("hold_exit_state", pwr_state_o, 3);
    check_eq("hold_exit_qreqn", qreqn_o, 1);
    check_eq("hold_exit_clk_en", clk_en_o, 1);
    wake_req_i = 1'b0;
    qactive_i  = 1'b1;
    qacceptn_i = 1'b1;
    tick(3);
    check_eq("hold_run_state", pwr_state_o, 0);
    check_eq("hold_run_err", proto_err_o, 0);

    // Protocol error: accept low while in RUN, sticky through the flow
    qacceptn_i = 1'b0;
    tick(2);
    check_eq("err_early", proto_err_o, 0);
    tick(1);
    check_eq("err_set", proto_err_o, 1);
    qactive_i = 1'b0;
    tick(10);
    check_eq("err_sticky", proto_err_o, 1);
    check_eq("err_state_stop", pwr_state_o, 2);
    check_eq("err_clk_en_stop", clk_en_o, 0);

    // Asynchronous reset mid-cycle while STOPPED
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_qreqn", qreqn_o, 1);
    check_eq("async_rst_clk_en", clk_en_o, 1);
    check_eq("async_rst_state", pwr_state_o, 0);
    check_eq("async_rst_err", proto_err_o, 0);

    // Full cycle holding STOPPED for 10 cycles, then statistics
    qacceptn_i = 1'b1;
    qactive_i  = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(3);
    qactive_i = 1'b0;
    tick(6);
    check_eq("stat_state_req", pwr_state_o, 1);
    qacceptn_i = 1'b0;
    tick(3);
    check_eq("stat_state_stop", pwr_state_o, 2);
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i == 7) qactive_i = 1'b1;
      check_eq("stat_state_hold", pwr_state_o, (i == 10) ? 32'd3 : 32'd2);
    end
    qacceptn_i = 1'b1;
    tick(3);
    check_eq("stat_state_run", pwr_state_o, 0);
    check_eq("stat_err", proto_err_o, 0);
`ifdef QCH_STATS_EN
    check_eq("stat_stop_cnt", stop_cnt_o, 1);
    check_eq("stat_stop_cycles", stop_cycles_o, 10);
`else
    check_eq("stat_stop_cnt", stop_cnt_o, 0);
    check_eq("stat_stop_cycles", stop_cycles_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
